// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared constants and queue entry type for the fetch sequencer
package ifetch_pkg;

  localparam int IMEM_AW = 7;
  localparam int INST_W  = 32;
  localparam logic [5:0] OPC_J = 6'b000010;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - circular prefetch FIFO of fetched {pc, inst} entries
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A push into a full queue only lands when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_sequencer.sv
// rtl/ifetch_sequencer.sv - fetch PC, next-PC logic and prefetch queue front end
// Optional j-opcode predecode redirection is enabled by IFETCH_JUMP_PREDECODE_EN.
module ifetch_sequencer
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INST_W-1:0]  imem_data,
  output logic               inst_valid,
  output logic [INST_W-1:0]  inst_data,
  output logic [31:0]        inst_pc,
  input  logic               inst_ready,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               stall_fetch
);

  logic [31:0]                pc_q;
  logic [31:0]                pc_plus4;
  logic [31:0]                next_pc;
  logic                       pop;
  logic                       fetch_en;
  logic                       q_full;
  logic                       q_empty;
  logic [$clog2(DEPTH+1)-1:0] q_count;
  logic                       unused_count;
  fetch_entry_t               head;
  fetch_entry_t               push_entry;

  assign unused_count = ^q_count;

  assign inst_valid = !q_empty;
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;
  assign imem_addr  = pc_q[IMEM_AW+1:2];

  assign pop      = inst_valid && inst_ready;
  assign fetch_en = !stall_fetch && (!q_full || pop) && !redirect_valid;

  assign push_entry.pc   = pc_q;
  assign push_entry.inst = imem_data;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef IFETCH_JUMP_PREDECODE_EN
  // The j word is still queued; only the fetch stream follows its target.
  assign next_pc = (imem_data[31:26] == OPC_J) ?
                   {pc_plus4[31:28], imem_data[25:0], 2'b00} : pc_plus4;
`else
  assign next_pc = pc_plus4;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & ~32'd3;
    end else if (fetch_en) begin
      pc_q <= next_pc;
    end
  end

  ifetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fetch_en),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

endmodule

// File: tb/tb_ifetch_sequencer.sv
// tb/tb_ifetch_sequencer.sv - randomized and directed bench against a queue-level fetch model
module tb_ifetch_sequencer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stall_fetch = 1'b0;

  logic [31:0] mem [128];
  assign imem_data = mem[imem_addr];

  ifetch_sequencer #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_fetch    (stall_fetch)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  ent_t        mq[$];
  logic [31:0] mpc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] inst);
    logic [31:0] p4;
    p4 = pc + 32'd4;
`ifdef IFETCH_JUMP_PREDECODE_EN
    if (inst[31:26] == 6'b000010) return {p4[31:28], inst[25:0], 2'b00};
`endif
    return p4;
  endfunction

  task automatic model_reset();
    mq.delete();
    mpc = 32'd0;
  endtask

  task automatic compare_model();
    check("valid", {31'd0, inst_valid}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      check("inst_pc", inst_pc, mq[0].pc);
      check("inst_data", inst_data, mq[0].inst);
    end
    check("imem_addr", {25'd0, imem_addr}, {25'd0, mpc[8:2]});
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, compare after the next edge.
  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc, input bit stall);
    bit pop, fetch;
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    stall_fetch    = stall;
    pop   = (mq.size() != 0) && rdy;
    fetch = !stall && (mq.size() < DEPTH || pop) && !redir;
    if (pop) void'(mq.pop_front());
    if (redir) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else if (fetch) begin
      mq.push_back('{pc: mpc, inst: mem[mpc[8:2]]});
      mpc = model_next(mpc, mem[mpc[8:2]]);
    end
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] exp_after_j;
    for (int i = 0; i < 128; i++) begin
      w = $urandom;
      if (w[31:26] == 6'b000010) w[31:26] = 6'b000011;
      mem[i] = w;
    end
    mem[8] = {6'b000010, 26'd13};

    // reset values
    @(negedge clk);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_imem_addr", {25'd0, imem_addr}, 32'd0);

    // reset-to-fetch
    rst_n = 1'b1;
    model_reset();
    cycle(1, 0, 0, 0);
    check("rf_pc0", inst_pc, 32'h00);
    check("rf_data0", inst_data, mem[0]);
    cycle(1, 0, 0, 0);
    check("rf_pc1", inst_pc, 32'h04);
    cycle(1, 0, 0, 0);
    check("rf_pc2", inst_pc, 32'h08);

    // backpressure from reset
    do_reset();
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
    check("bp_pc_hold", {25'd0, imem_addr}, DEPTH);
    for (int i = 0; i <= DEPTH; i++) begin
      check("bp_valid", {31'd0, inst_valid}, 32'd1);
      check("bp_seq", inst_pc, 32'(4 * i));
      cycle(1, 0, 0, 0);
    end

    // redirect while the head is popped
    check("rd_pre_valid", {31'd0, inst_valid}, 32'd1);
    cycle(1, 1, 32'h0C, 0);
    check("rd_n1_valid", {31'd0, inst_valid}, 32'd0);
    cycle(1, 0, 0, 0);
    check("rd_n2_pc", inst_pc, 32'h0C);
    check("rd_n2_data", inst_data, mem[3]);

    // wrap past word 127, low redirect bits ignored
    cycle(1, 1, 32'h1FD, 0);
    cycle(1, 0, 0, 0);
    check("wrap_pc0", inst_pc, 32'h1FC);
    check("wrap_addr", {25'd0, imem_addr}, 32'd0);
    cycle(1, 0, 0, 0);
    check("wrap_pc1", inst_pc, 32'h200);
    check("wrap_data1", inst_data, mem[0]);

    // j 13 at 0x20
`ifdef IFETCH_JUMP_PREDECODE_EN
    exp_after_j = 32'h34;
`else
    exp_after_j = 32'h24;
`endif
    cycle(1, 1, 32'h1C, 0);
    cycle(1, 0, 0, 0);
    check("pd_pc0", inst_pc, 32'h1C);
    cycle(1, 0, 0, 0);
    check("pd_pc1", inst_pc, 32'h20);
    cycle(1, 0, 0, 0);
    check("pd_pc2", inst_pc, exp_after_j);

    // asynchronous reset between edges with a full queue
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 0, 0);
    check("ar_full_valid", {31'd0, inst_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, inst_valid}, 32'd0);
    check("ar_imem_addr", {25'd0, imem_addr}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic, including a few planted jumps
    for (int k = 0; k < 6; k++) mem[$urandom_range(127)] = {6'b000010, 26'($urandom)};
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(3) != 0, $urandom_range(19) == 0, $urandom, $urandom_range(6) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
